// File: rtl/expansion.sv
// -----------------------------------------------------------------------------
// expansion
//
// Downward expander for a 12-bit signed audio sample stream. Quiet passages
// are attenuated further, loud passages pass at unity gain, restoring the
// dynamic range taken away by an upstream compressor.
//
// Each accepted sample walks a five-state pipeline, one cycle per state:
//   IDLE -> ENV (envelope follower) -> GAIN (gain law) -> MUL -> OUT -> IDLE
//
// Handshake semantics:
//   ready     one-cycle strobe. It is accepted only in IDLE. In any other
//             state the sample is dropped and overrun pulses in that same
//             cycle.
//   done      high for exactly one cycle (the OUT state). It is coincident
//             with the new modified_sample value. A ready in cycle N yields
//             done in cycle N+4. modified_sample holds between updates.
//
// Ports:
//   clock             system clock
//   reset             asynchronous, active-low reset
//   ready             new-sample strobe
//   incoming_sample   12-bit two's complement input sample
//   expansion_amount  0 = bypass, 1/2/3 = attenuation slope x1/x2/x4
//   modified_sample   12-bit expanded output sample
//   done              output-updated strobe
//   overrun           sample-dropped strobe
//   debug_state       current FSM state encoding (IDLE=0 .. OUT=4)
// -----------------------------------------------------------------------------
module expansion #(
    parameter int SAMPLING_RATE = 24000,
    parameter int THRESHOLD     = 256,
    parameter int RELEASE_SHIFT = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ready,
    input  logic signed [11:0] incoming_sample,
    input  logic        [1:0]  expansion_amount,
    output logic signed [11:0] modified_sample,
    output logic               done,
    output logic               overrun,
    output logic        [2:0]  debug_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ENV  = 3'd1,
        GAIN = 3'd2,
        MUL  = 3'd3,
        OUT  = 3'd4
    } state_t;

    // The sample rate is informational only; nothing in the datapath uses it.
    logic unused_rate;
    assign unused_rate = (SAMPLING_RATE > 0);

    localparam logic [12:0] THRESH13 = 13'(THRESHOLD);
    localparam logic [8:0]  UNITY    = 9'd256;

    state_t             state_q,    state_d;
    logic signed [11:0] sample_q,   sample_d;
    logic        [1:0]  amount_q,   amount_d;
    logic        [10:0] env_q,      env_d;
    logic        [8:0]  gain_q,     gain_d;
    logic signed [11:0] modified_q, modified_d;

    // ------------------------------------------------------------------
    // Envelope follower: instant attack, exponential release.
    // ------------------------------------------------------------------
    logic [11:0] neg_w;
    logic [10:0] abs_w;
    logic [10:0] env_next_w;

    assign neg_w = (~sample_q) + 12'd1;

    always_comb begin
        abs_w = sample_q[10:0];
        if (sample_q[11]) begin
            // -2048 has no positive 12-bit counterpart; saturate to 2047.
            if (sample_q == -12'sd2048) begin
                abs_w = 11'd2047;
            end else begin
                abs_w = neg_w[10:0];
            end
        end
    end

    always_comb begin
        env_next_w = env_q;
        if (abs_w > env_q) begin
            env_next_w = abs_w;
        end else begin
            // Subtracting a right-shifted copy of itself can never underflow.
            env_next_w = env_q - (env_q >> RELEASE_SHIFT);
        end
    end

    // ------------------------------------------------------------------
    // Gain law, Q1.8: 256 is unity. Below the threshold the gain falls
    // linearly with the envelope deficit, steeper for larger amounts.
    // 13 bits hold the largest deficit shifted left by two without wrap.
    // ------------------------------------------------------------------
    logic [12:0] deficit_w;
    logic [12:0] atten_w;
    logic [12:0] unity_minus_w;
    logic [8:0]  gain_next_w;

    assign deficit_w     = THRESH13 - {2'b00, env_q};
    assign atten_w       = deficit_w << (amount_q - 2'd1);
    assign unity_minus_w = 13'd256 - atten_w;

    always_comb begin
        gain_next_w = UNITY;
        if (amount_q != 2'd0 && {2'b00, env_q} < THRESH13) begin
            if (atten_w >= 13'd256) begin
                gain_next_w = 9'd0;
            end else begin
                gain_next_w = unity_minus_w[8:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Multiply and rescale. Gain never exceeds 1.0, so the arithmetic
    // right shift always lands inside the 12-bit signed range.
    // ------------------------------------------------------------------
    logic signed [21:0] product_w;
    logic signed [11:0] result_w;

    assign product_w = sample_q * $signed({1'b0, gain_q});
    assign result_w  = 12'(product_w >>> 8);

    // ------------------------------------------------------------------
    // FSM next state and datapath register updates.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        amount_d   = amount_q;
        env_d      = env_q;
        gain_d     = gain_q;
        modified_d = modified_q;

        case (state_q)
            IDLE: begin
                if (ready) begin
                    sample_d = incoming_sample;
                    amount_d = expansion_amount;
                    state_d  = ENV;
                end
            end
            ENV: begin
                // Envelope tracks in bypass too, so mode switches are clean.
                env_d   = env_next_w;
                state_d = GAIN;
            end
            GAIN: begin
                gain_d  = gain_next_w;
                state_d = MUL;
            end
            MUL: begin
                // Registered on the MUL->OUT edge so the value is visible
                // in the same cycle as done.
                modified_d = result_w;
                state_d    = OUT;
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sample_q   <= '0;
            amount_q   <= '0;
            env_q      <= '0;
            gain_q     <= '0;
            modified_q <= '0;
        end else begin
            state_q    <= state_d;
            sample_q   <= sample_d;
            amount_q   <= amount_d;
            env_q      <= env_d;
            gain_q     <= gain_d;
            modified_q <= modified_d;
        end
    end

    assign modified_sample = modified_q;
    assign done            = (state_q == OUT);
    assign overrun         = ready && (state_q != IDLE);
    assign debug_state     = state_q;

endmodule

// File: tb/tb_expansion.sv
module tb_expansion;

    logic               clock;
    logic               reset;
    logic               ready;
    logic signed [11:0] incoming_sample;
    logic        [1:0]  expansion_amount;
    logic signed [11:0] modified_sample;
    logic               done;
    logic               overrun;
    logic        [2:0]  debug_state;

    int tests_run    = 0;
    int tests_failed = 0;

    expansion dut (
        .clock            (clock),
        .reset            (reset),
        .ready            (ready),
        .incoming_sample  (incoming_sample),
        .expansion_amount (expansion_amount),
        .modified_sample  (modified_sample),
        .done             (done),
        .overrun          (overrun),
        .debug_state      (debug_state)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Driver tasks. All driving and sampling happens 1 time unit after posedge.
    task automatic do_reset();
        reset = 1'b0;
        ready = 1'b0;
        incoming_sample  = '0;
        expansion_amount = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    // Strobe one sample, wait (bounded) for done, then one more cycle so the
    // FSM is back in IDLE. lat = cycles from strobe to done (-1 if none).
    task automatic run_sample(input logic signed [11:0] s, input logic [1:0] a,
                              output logic signed [11:0] out, output int lat,
                              output logic done_after);
        ready = 1'b1;
        incoming_sample  = s;
        expansion_amount = a;
        lat = -1;
        out = '0;
        done_after = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock);
            #1 ready = 1'b0;
            if (done) begin
                lat = k;
                out = modified_sample;
                @(posedge clock);
                #1 done_after = done;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic signed [11:0] out;
        int lat;
        logic da;
        reset = 1'b0;
        incoming_sample  = 12'sd555;
        expansion_amount = 2'd1;
        for (int i = 0; i < 3; i++) begin
            ready = (i % 2 == 0);
            #1;
            tests_run++;
            if (modified_sample !== 12'sd0 || done !== 1'b0 || overrun !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: got out=%0d done=%b ovr=%b, want 0/0/0",
                         i, modified_sample, done, overrun);
            end
            @(posedge clock);
            #1;
        end
        tests_run++;
        if (debug_state !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d, want 0", debug_state);
        end
        ready = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        run_sample(12'sd0, 2'd1, out, lat, da);
        tests_run++;
        if (lat !== 4 || out !== 12'sd0 || da !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_first: got lat=%0d out=%0d done_after=%b, want 4/0/0",
                     lat, out, da);
        end
    endtask

    // Each scenario resets, then plays a vector list and checks each result.
    task automatic test_sequence(input string name, input int n,
                                 input logic signed [11:0] s [4],
                                 input logic [1:0] a [4],
                                 input logic signed [11:0] exp_out [4]);
        logic signed [11:0] out;
        int lat;
        logic da;
        do_reset();
        for (int i = 0; i < n; i++) begin
            run_sample(s[i], a[i], out, lat, da);
            tests_run++;
            if (lat !== 4 || out !== exp_out[i] || da !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s[%0d]: got lat=%0d out=%0d done_after=%b, want 4/%0d/0",
                         name, i, lat, out, da, exp_out[i]);
            end
        end
    endtask

    task automatic test_bypass();
        logic signed [11:0] s [4] = '{-12'sd100, 12'sd2047, 12'sd0, 12'sd0};
        logic        [1:0]  a [4] = '{2'd0, 2'd0, 2'd0, 2'd0};
        logic signed [11:0] e [4] = '{-12'sd100, 12'sd2047, 12'sd0, 12'sd0};
        test_sequence("bypass", 2, s, a, e);
    endtask

    task automatic test_expand_x1();
        // env 100 -> gain 100 -> 39; env 94 -> gain 94 -> floor(-9400/256) = -37
        logic signed [11:0] s [4] = '{12'sd100, -12'sd100, 12'sd0, 12'sd0};
        logic        [1:0]  a [4] = '{2'd1, 2'd1, 2'd1, 2'd1};
        logic signed [11:0] e [4] = '{12'sd39, -12'sd37, 12'sd0, 12'sd0};
        test_sequence("expand_x1", 2, s, a, e);
    endtask

    task automatic test_unity_release();
        // env 300 unity; env 282 (out 0); env 265 still unity -> 10
        logic signed [11:0] s [4] = '{12'sd300, 12'sd0, 12'sd10, 12'sd0};
        logic        [1:0]  a [4] = '{2'd2, 2'd2, 2'd2, 2'd2};
        logic signed [11:0] e [4] = '{12'sd300, 12'sd0, 12'sd10, 12'sd0};
        test_sequence("unity_release", 3, s, a, e);
    endtask

    task automatic test_hard_gate();
        // deficit 206 << 2 = 824 -> gain 0
        logic signed [11:0] s1 [4] = '{12'sd50, 12'sd0, 12'sd0, 12'sd0};
        logic signed [11:0] s2 [4] = '{-12'sd2048, 12'sd0, 12'sd0, 12'sd0};
        logic        [1:0]  a  [4] = '{2'd3, 2'd3, 2'd3, 2'd3};
        logic signed [11:0] e1 [4] = '{12'sd0, 12'sd0, 12'sd0, 12'sd0};
        logic signed [11:0] e2 [4] = '{-12'sd2048, 12'sd0, 12'sd0, 12'sd0};
        test_sequence("hard_gate", 1, s1, a, e1);
        test_sequence("extreme", 1, s2, a, e2);
    endtask

    task automatic test_overrun();
        int n_done = 0;
        int first_k = -1;
        logic signed [11:0] first_val = '0;
        do_reset();
        ready = 1'b1;
        incoming_sample  = 12'sd123;
        expansion_amount = 2'd0;
        @(posedge clock);
        #1 ready = 1'b0;
        @(posedge clock);
        #1;
        ready = 1'b1;
        incoming_sample = 12'sd999;
        #1;
        tests_run++;
        if (overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_pulse: got %b, want 1", overrun);
        end
        for (int k = 3; k <= 12; k++) begin
            @(posedge clock);
            #1 ready = 1'b0;
            if (done) begin
                n_done++;
                if (first_k < 0) begin
                    first_k = k;
                    first_val = modified_sample;
                end
            end
        end
        tests_run++;
        if (n_done !== 1 || first_k !== 4 || first_val !== 12'sd123) begin
            tests_failed++;
            $display("FAIL overrun_done: got n=%0d k=%0d val=%0d, want 1/4/123",
                     n_done, first_k, first_val);
        end
    endtask

    task automatic test_back_to_back();
        int n_done = 0;
        int first_k = -1;
        logic signed [11:0] first_val = '0;
        do_reset();
        ready = 1'b1;
        incoming_sample  = 12'sd40;
        expansion_amount = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock);
            #1 ready = 1'b0;
        end
        tests_run++;
        if (done !== 1'b1 || modified_sample !== 12'sd40) begin
            tests_failed++;
            $display("FAIL b2b_first: got done=%b out=%0d, want 1/40", done, modified_sample);
        end
        // ready during OUT is dropped
        ready = 1'b1;
        incoming_sample = 12'sd77;
        #1;
        tests_run++;
        if (overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_out_drop: got overrun=%b, want 1", overrun);
        end
        // ready in the following IDLE cycle is accepted
        @(posedge clock);
        #1;
        incoming_sample = -12'sd5;
        #1;
        tests_run++;
        if (overrun !== 1'b0 || debug_state !== 3'd0) begin
            tests_failed++;
            $display("FAIL b2b_idle_accept: got overrun=%b state=%0d, want 0/0",
                     overrun, debug_state);
        end
        for (int k = 6; k <= 14; k++) begin
            @(posedge clock);
            #1 ready = 1'b0;
            if (done) begin
                n_done++;
                if (first_k < 0) begin
                    first_k = k;
                    first_val = modified_sample;
                end
            end
        end
        tests_run++;
        if (n_done !== 1 || first_k !== 9 || first_val !== -12'sd5) begin
            tests_failed++;
            $display("FAIL b2b_second: got n=%0d k=%0d val=%0d, want 1/9/-5",
                     n_done, first_k, first_val);
        end
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        logic signed [11:0] out;
        int lat;
        logic da;
        do_reset();
        ready = 1'b1;
        incoming_sample  = 12'sd500;
        expansion_amount = 2'd0;
        @(posedge clock);
        #1 ready = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        tests_run++;
        if (done !== 1'b0 || modified_sample !== 12'sd0 || overrun !== 1'b0 ||
            debug_state !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_async: got done=%b out=%0d ovr=%b state=%0d, want 0/0/0/0",
                     done, modified_sample, overrun, debug_state);
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clock);
            #1;
            if (done) n_done++;
        end
        tests_run++;
        if (n_done !== 0 || debug_state !== 3'd0 || modified_sample !== 12'sd0) begin
            tests_failed++;
            $display("FAIL reset_mid_after: got dones=%0d state=%0d out=%0d, want 0/0/0",
                     n_done, debug_state, modified_sample);
        end
        // envelope was cleared: first x1 sample of 100 gives 39 again
        run_sample(12'sd100, 2'd1, out, lat, da);
        tests_run++;
        if (lat !== 4 || out !== 12'sd39) begin
            tests_failed++;
            $display("FAIL reset_mid_env: got lat=%0d out=%0d, want 4/39", lat, out);
        end
    endtask

    initial begin
        reset = 1'b0;
        ready = 1'b0;
        incoming_sample  = '0;
        expansion_amount = '0;
        @(posedge clock);
        #1;
        test_reset();
        test_bypass();
        test_expand_x1();
        test_unity_release();
        test_hard_gate();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
